// File: rtl/qoi_frame_decoder.sv
// Streaming QOI decoder: parses the header and writes RGB332 pixels to frame-buffer port A.
// Optional build macro QOI_HDR_CHECK_EN enables magic, image-size and end-marker validation.
module qoi_frame_decoder #(
  parameter int MAX_W = 640,
  parameter int MAX_H = 480,
  parameter int AW    = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {S_HDR, S_OP, S_ARG, S_RUN, S_TAIL, S_DONE, S_ERR} state_t;
  typedef enum logic [1:0] {K_RGB, K_RGBA, K_LUMA} kind_t;

`ifdef QOI_HDR_CHECK_EN
  localparam int WW = 32;
  localparam int HW = 32;
`else
  localparam int WW = 10;
  localparam int HW = 9;
`endif
  localparam logic [AW-1:0] ADDR_LAST = AW'(MAX_W * MAX_H - 1);

  state_t        state_q, state_d;
  kind_t         kind_q, kind_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [WW-1:0] width_q, width_d;
  logic [HW-1:0] height_q, height_d;
  logic [18:0]   total_q, total_d;
  logic [18:0]   pix_q, pix_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [5:0]    opb_q, opb_d;
  logic [5:0]    run_q, run_d;
  logic [7:0]    a0_q, a0_d, a1_q, a1_d, a2_q, a2_d;
  logic [7:0]    pr_q, pr_d, pg_q, pg_d, pb_q, pb_d, pa_q, pa_d;
  logic          in_ready_q, in_ready_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic [31:0]   idx_q [64];
  logic          idx_we, idx_clr;
  logic [5:0]    idx_addr;
  logic [31:0]   idx_wdata;

  logic          xfer, emit, arg_done, pix_last, hdr_bad;
  logic [7:0]    px_r, px_g, px_b, px_a;
  logic [7:0]    dg, dr, db;
  logic [18:0]   total_w;
  logic [7:0]    magic_byte;

  function automatic logic [5:0] qoi_hash(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b, input logic [7:0] a);
    logic [7:0] s;
    s = r * 8'd3 + g * 8'd5 + b * 8'd7 + a * 8'd11;
    return s[5:0];
  endfunction

  assign xfer     = in_valid && in_ready_q;
  assign total_w  = 19'(width_q[9:0]) * 19'(height_q[8:0]);
  assign pix_last = (pix_q + 19'd1) == total_q;
  assign arg_done = (kind_q == K_LUMA) ||
                    (kind_q == K_RGB  && cnt_q == 4'd2) ||
                    (kind_q == K_RGBA && cnt_q == 4'd3);

  // LUMA deltas: green bias 32, red/blue differences relative to green with bias 8.
  assign dg = {2'b00, opb_q} - 8'd32;
  assign dr = dg + {4'b0000, in_data[7:4]} - 8'd8;
  assign db = dg + {4'b0000, in_data[3:0]} - 8'd8;

  always_comb begin
    case (cnt_q[1:0])
      2'd0:    magic_byte = 8'h71;
      2'd1:    magic_byte = 8'h6F;
      2'd2:    magic_byte = 8'h69;
      default: magic_byte = 8'h66;
    endcase
  end

`ifdef QOI_HDR_CHECK_EN
  assign hdr_bad = (width_q == '0) || (width_q > 32'(MAX_W)) ||
                   (height_q == '0) || (height_q > 32'(MAX_H));
`else
  assign hdr_bad = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    cnt_d     = cnt_q;
    width_d   = width_q;
    height_d  = height_q;
    total_d   = total_q;
    pix_d     = pix_q;
    addr_d    = addr_q;
    opb_d     = opb_q;
    run_d     = run_q;
    a0_d      = a0_q;
    a1_d      = a1_q;
    a2_d      = a2_q;
    pr_d      = pr_q;
    pg_d      = pg_q;
    pb_d      = pb_q;
    pa_d      = pa_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    px_r      = pr_q;
    px_g      = pg_q;
    px_b      = pb_q;
    px_a      = pa_q;
    emit      = 1'b0;
    idx_we    = 1'b0;
    idx_clr   = 1'b0;

    case (state_q)
      S_HDR: begin
        if (xfer) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q >= 4'd4 && cnt_q <= 4'd7) width_d = {width_q[WW-9:0], in_data};
          if (cnt_q >= 4'd8 && cnt_q <= 4'd11) height_d = {height_q[HW-9:0], in_data};
`ifdef QOI_HDR_CHECK_EN
          if (cnt_q <= 4'd3 && in_data != magic_byte) state_d = S_ERR;
`endif
          if (cnt_q == 4'd13) begin
            cnt_d   = 4'd0;
            total_d = total_w;
            if (hdr_bad)              state_d = S_ERR;
            else if (total_w == '0)   state_d = S_TAIL;
            else                      state_d = S_OP;
          end
        end
      end

      S_OP: begin
        if (xfer) begin
          casez (in_data)
            8'hFE: begin
              kind_d  = K_RGB;
              cnt_d   = 4'd0;
              state_d = S_ARG;
            end
            8'hFF: begin
              kind_d  = K_RGBA;
              cnt_d   = 4'd0;
              state_d = S_ARG;
            end
            8'b00??????: begin
              {px_r, px_g, px_b, px_a} = idx_q[in_data[5:0]];
              emit   = 1'b1;
              idx_we = 1'b1;
            end
            8'b01??????: begin
              px_r   = pr_q + {6'd0, in_data[5:4]} - 8'd2;
              px_g   = pg_q + {6'd0, in_data[3:2]} - 8'd2;
              px_b   = pb_q + {6'd0, in_data[1:0]} - 8'd2;
              emit   = 1'b1;
              idx_we = 1'b1;
            end
            8'b10??????: begin
              kind_d  = K_LUMA;
              opb_d   = in_data[5:0];
              cnt_d   = 4'd0;
              state_d = S_ARG;
            end
            default: begin
              emit  = 1'b1;
              run_d = in_data[5:0];
              if (in_data[5:0] != 6'd0) state_d = S_RUN;
            end
          endcase
        end
      end

      S_ARG: begin
        if (xfer) begin
          cnt_d = cnt_q + 4'd1;
          case (cnt_q[1:0])
            2'd0:    a0_d = in_data;
            2'd1:    a1_d = in_data;
            2'd2:    a2_d = in_data;
            default: ;
          endcase
          if (arg_done) begin
            state_d = S_OP;
            emit    = 1'b1;
            idx_we  = 1'b1;
            case (kind_q)
              K_RGB: begin
                px_r = a0_q;
                px_g = a1_q;
                px_b = in_data;
              end
              K_RGBA: begin
                px_r = a0_q;
                px_g = a1_q;
                px_b = a2_q;
                px_a = in_data;
              end
              default: begin
                px_r = pr_q + dr;
                px_g = pg_q + dg;
                px_b = pb_q + db;
              end
            endcase
          end
        end
      end

      S_RUN: begin
        emit  = 1'b1;
        run_d = run_q - 6'd1;
        if (run_q == 6'd1) state_d = S_OP;
      end

      S_TAIL: begin
        if (xfer) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) state_d = S_DONE;
`ifdef QOI_HDR_CHECK_EN
          if ((cnt_q < 4'd7 && in_data != 8'h00) || (cnt_q == 4'd7 && in_data != 8'h01))
            state_d = S_ERR;
`endif
        end
      end

      S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR;
          cnt_d   = 4'd0;
          pix_d   = '0;
          addr_d  = '0;
          pr_d    = 8'd0;
          pg_d    = 8'd0;
          pb_d    = 8'd0;
          pa_d    = 8'd255;
          idx_clr = 1'b1;
        end
      end

      default: state_d = S_HDR;
    endcase

    // The pixel that fills the image diverts to TAIL, discarding any remaining run.
    if (emit) begin
      wr_en_d   = 1'b1;
      wr_addr_d = addr_q;
      wr_data_d = {px_r[7:5], px_g[7:5], px_b[7:6]};
      addr_d    = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
      pix_d     = pix_q + 19'd1;
      pr_d      = px_r;
      pg_d      = px_g;
      pb_d      = px_b;
      pa_d      = px_a;
      if (pix_last) begin
        state_d = S_TAIL;
        cnt_d   = 4'd0;
      end
    end

    idx_addr   = qoi_hash(px_r, px_g, px_b, px_a);
    idx_wdata  = {px_r, px_g, px_b, px_a};
    in_ready_d = (state_d == S_HDR) || (state_d == S_OP) || (state_d == S_ARG) || (state_d == S_TAIL);
    busy_d     = (state_d != S_DONE) && (state_d != S_ERR);
    done_d     = (state_d == S_DONE);
`ifdef QOI_HDR_CHECK_EN
    error_d    = (state_d == S_ERR);
`else
    error_d    = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_HDR;
      kind_q     <= K_RGB;
      cnt_q      <= 4'd0;
      width_q    <= '0;
      height_q   <= '0;
      total_q    <= '0;
      pix_q      <= '0;
      addr_q     <= '0;
      opb_q      <= '0;
      run_q      <= '0;
      a0_q       <= '0;
      a1_q       <= '0;
      a2_q       <= '0;
      pr_q       <= 8'd0;
      pg_q       <= 8'd0;
      pb_q       <= 8'd0;
      pa_q       <= 8'd255;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      cnt_q      <= cnt_d;
      width_q    <= width_d;
      height_q   <= height_d;
      total_q    <= total_d;
      pix_q      <= pix_d;
      addr_q     <= addr_d;
      opb_q      <= opb_d;
      run_q      <= run_d;
      a0_q       <= a0_d;
      a1_q       <= a1_d;
      a2_q       <= a2_d;
      pr_q       <= pr_d;
      pg_q       <= pg_d;
      pb_q       <= pb_d;
      pa_q       <= pa_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) idx_q[i] <= '0;
    end else if (idx_clr) begin
      for (int i = 0; i < 64; i++) idx_q[i] <= '0;
    end else if (idx_we) begin
      idx_q[idx_addr] <= idx_wdata;
    end
  end

  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_qoi_frame_decoder.sv
// Table-driven bench for qoi_frame_decoder with a write scoreboard and hand-written corner sequences.
// Covers the QOI_HDR_CHECK_EN build when that macro is defined.
module tb_qoi_frame_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, wr_en, busy, done, error;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;

  int total = 0;
  int bad = 0;
  bit monitorOn = 1'b1;
  int rawWrites = 0;

  typedef struct packed {
    logic [18:0] addr;
    logic [7:0]  data;
  } wr_t;
  wr_t sb[$];
  wr_t sbHead;

  typedef struct {
    string       name;
    int          w;
    int          h;
    int          nops;
    logic [63:0] ops;
    int          npix;
    logic [31:0] px;
  } vec_t;
  vec_t vecs[$];

  qoi_frame_decoder dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_en) begin
      rawWrites++;
      if (monitorOn) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_write: got addr %0d data %0h expected no write", wr_addr, wr_data);
        end else begin
          sbHead = sb.pop_front();
          checkOutput("wr_addr", 32'(wr_addr), 32'(sbHead.addr));
          checkOutput("wr_data", 32'(wr_data), 32'(sbHead.data));
        end
      end
    end
  end

  task automatic sendByte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL in_ready_timeout: got in_ready 0 expected 1 for byte %0h", b);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic sendHeader(input logic [31:0] w, input logic [31:0] h, input logic [7:0] m3);
    sendByte(8'h71); sendByte(8'h6F); sendByte(8'h69); sendByte(m3);
    for (int k = 3; k >= 0; k--) sendByte(w[8*k +: 8]);
    for (int k = 3; k >= 0; k--) sendByte(h[8*k +: 8]);
    sendByte(8'h03); sendByte(8'h00);
  endtask

  task automatic sendMarker();
    for (int k = 0; k < 7; k++) sendByte(8'h00);
    sendByte(8'h01);
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic addVec(input string name, input int w, input int h, input int nops,
                        input logic [63:0] ops, input int npix, input logic [31:0] px);
    vec_t v;
    v.name = name; v.w = w; v.h = h; v.nops = nops; v.ops = ops; v.npix = npix; v.px = px;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input int i);
    vec_t v;
    v = vecs[i];
    for (int p = 0; p < v.npix; p++) sb.push_back({19'(p), v.px[31-8*p -: 8]});
    sendHeader(32'(v.w), 32'(v.h), 8'h66);
    for (int k = 0; k < v.nops; k++) sendByte(v.ops[63-8*k -: 8]);
    sendMarker();
    @(negedge clk);
    checkOutput({v.name, "_done"}, 32'(done), 32'd1);
    checkOutput({v.name, "_idle"}, {30'd0, busy, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput({v.name, "_writes_left"}, 32'(sb.size()), 32'd0);
    pulseStart();
    checkOutput({v.name, "_restart"}, {30'd0, busy, done}, 32'd2);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int snap;

    addVec("rgb_run",       2, 1, 5, 64'hFEFF0000C0000000, 2, 32'hE0E00000);
    addVec("diff_wrap",     1, 1, 1, 64'h4000000000000000, 1, 32'hFF000000);
    addVec("luma",          1, 1, 2, 64'h8000000000000000, 1, 32'hDF000000);
    addVec("index_restore", 3, 1, 6, 64'hFEFF000040320000, 3, 32'hE0FFE000);
    addVec("run_trunc",     4, 1, 5, 64'hFE00FF00FD000000, 4, 32'h1C1C1C1C);
    addVec("rgba_index",    2, 1, 6, 64'hFF20406010300000, 2, 32'h29290000);
    addVec("index_cleared", 1, 1, 1, 64'h3000000000000000, 1, 32'h00000000);
`ifndef QOI_HDR_CHECK_EN
    addVec("zero_size",     0, 1, 0, 64'h0000000000000000, 0, 32'h00000000);
`endif

    // Reset state, then in_ready rises one cycle after release.
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs", {26'd0, in_ready, wr_en, busy, done, error, 1'b0}, 32'd0);
    checkOutput("reset_addr_data", {5'd0, wr_addr, wr_data}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_ready_busy", {30'd0, in_ready, busy}, 32'd3);

    for (int i = 0; i < vecs.size(); i++) applyStimulus(i);

    // Pixel latency: strobe in the cycle after the completing byte.
    sb.push_back({19'd0, 8'hFF});
    sendHeader(32'd1, 32'd1, 8'h66);
    checkOutput("latency_no_early_write", 32'(wr_en), 32'd0);
    sendByte(8'h40);
    @(negedge clk);
    checkOutput("latency_wr_en", 32'(wr_en), 32'd1);
    sendMarker();
    @(negedge clk);
    checkOutput("latency_done", 32'(done), 32'd1);
    pulseStart();

    // Long run interrupted by reset.
    monitorOn = 1'b0;
    sendHeader(32'd64, 32'd1, 8'h66);
    sendByte(8'hFE); sendByte(8'h00); sendByte(8'hFF); sendByte(8'h00);
    sendByte(8'hFD);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("run_wr_en", 32'(wr_en), 32'd1);
      checkOutput("run_addr", 32'(wr_addr), 32'(k + 1));
      checkOutput("run_data", 32'(wr_data), 32'h1C);
      checkOutput("run_in_ready", 32'(in_ready), 32'd0);
    end
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_outputs", {26'd0, in_ready, wr_en, busy, done, error, 1'b0}, 32'd0);
    checkOutput("abort_addr_data", {5'd0, wr_addr, wr_data}, 32'd0);
    snap = rawWrites;
    repeat (5) @(negedge clk);
    checkOutput("abort_no_writes", 32'(rawWrites - snap), 32'd0);
    rst = 1'b1;
    monitorOn = 1'b1;
    @(negedge clk);
    checkOutput("abort_recover", {30'd0, in_ready, busy}, 32'd3);

`ifdef QOI_HDR_CHECK_EN
    sendByte(8'h71); sendByte(8'h6F); sendByte(8'h69); sendByte(8'h78);
    @(negedge clk);
    checkOutput("bad_magic_state", {29'd0, error, in_ready, busy}, 32'd4);
    pulseStart();
    checkOutput("bad_magic_restart", {29'd0, error, in_ready, busy}, 32'd3);
    sendHeader(32'd641, 32'd1, 8'h66);
    @(negedge clk);
    checkOutput("wide_error", {30'd0, error, in_ready}, 32'd2);
    pulseStart();
`else
    sb.push_back({19'd0, 8'hFF});
    sendHeader(32'd1, 32'd1, 8'h78);
    sendByte(8'h40);
    sendMarker();
    @(negedge clk);
    checkOutput("unchecked_magic", {30'd0, done, error}, 32'd2);
    checkOutput("unchecked_writes_left", 32'(sb.size()), 32'd0);
    pulseStart();
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
